// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 9-bit accumulator/res CPU sequencer.
// Contents:
//   PC_W_DEF  default PC width
//   ST_*      sequencer state encodings (3-bit, legacy-compatible constants)
//   WS_*      decoder write_src codes (MEM/IMM/RES/ALU)
//   state_counts_cycle() - true for states that count toward cycle_count
package cpu_sequencer_pkg;

   localparam int unsigned PC_W_DEF = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_HALT   = 3'd6;

   localparam logic [1:0] WS_MEM = 2'b00;
   localparam logic [1:0] WS_IMM = 2'b01;
   localparam logic [1:0] WS_RES = 2'b10;
   localparam logic [1:0] WS_ALU = 2'b11;

   function automatic logic state_counts_cycle(input logic [2:0] st);
      return (st != ST_IDLE) && (st != ST_HALT);
   endfunction

endpackage

// File: rtl/cpu_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Ports:
//   clk    clock
//   clr_n  synchronous clear, active low
//   en     count enable; holds at all-ones once reached
//   count  current count value
module cpu_sequencer_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count_q <= '0;
      end else if (en && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, the fetch/decode/execute/mem/writeback
// FSM and the imem/dmem request handshakes.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   start                        leave IDLE
//   fetch_req/imem_ready/ir_load instruction fetch handshake and IR capture strobe
//   dec_*                        per-instruction strobes from the control decoder
//   branch_cond, target          branch flag and branch/jump destination
//   dmem_req/dmem_we/dmem_ready  data memory handshake
//   reg_we, res_we               one-cycle write enables issued in WB
//   pc, halted                   current PC and halt indication
//   cycle_count, retired_count   saturating activity counters
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             fetch_req,
   input  logic             imem_ready,
   output logic             ir_load,
   input  logic             dec_mem_read,
   input  logic             dec_mem_write,
   input  logic             dec_branch,
   input  logic             dec_jump,
   input  logic             dec_halt,
   input  logic             dec_cpin,
   input  logic             dec_cpout,
   input  logic [1:0]       dec_write_src,
   input  logic             branch_cond,
   input  logic [PC_W-1:0]  target,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             reg_we,
   output logic             res_we,
   output logic [PC_W-1:0]  pc,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retired_count
);

   logic [2:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_inc;
   logic            retire;

   // Every WB writes something (ALU/IMM/MEM/RES or cpout all go to the regfile), so the
   // write_src selection matters only to the datapath mux, not to the sequencer.
   logic unused_write_src;
   assign unused_write_src = ^dec_write_src;

   assign pc_inc = pc_q + PC_W'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (dec_halt) begin
               state_d = ST_HALT;
               retire  = 1'b1;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (dec_jump) begin
               pc_d    = target;
               state_d = ST_FETCH;
               retire  = 1'b1;
            end else if (dec_branch) begin
               pc_d    = branch_cond ? target : pc_inc;
               state_d = ST_FETCH;
               retire  = 1'b1;
            end else if (dec_mem_read || dec_mem_write) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (dmem_ready) begin
               if (dec_mem_read) begin
                  state_d = ST_WB;
               end else begin
                  pc_d    = pc_inc;
                  state_d = ST_FETCH;
                  retire  = 1'b1;
               end
            end
         end
         ST_WB: begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Outputs decode the state register; ir_load and dmem_we are additionally qualified
   // by the handshake/decoder inputs of the current cycle.
   assign fetch_req = (state_q == ST_FETCH);
   assign ir_load   = (state_q == ST_FETCH) && imem_ready;
   assign dmem_req  = (state_q == ST_MEM);
   assign dmem_we   = (state_q == ST_MEM) && dec_mem_write && !dec_mem_read;
   assign reg_we    = (state_q == ST_WB) && !dec_cpin;
   assign res_we    = (state_q == ST_WB) && dec_cpin;
   assign halted    = (state_q == ST_HALT);
   assign pc        = pc_q;

   cpu_sequencer_sat_counter #(
      .CNT_W (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .clr_n (reset_n),
      .en    (state_counts_cycle(state_q)),
      .count (cycle_count)
   );

   cpu_sequencer_sat_counter #(
      .CNT_W (CNT_W)
   ) u_retired_cnt (
      .clk   (clk),
      .clr_n (reset_n),
      .en    (retire),
      .count (retired_count)
   );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: drives directed and random instructions, acting as imem/dmem
// with configurable wait states, and checks against a per-instruction latency/PC model.
module tb_cpu_sequencer;

   localparam int K_ALU   = 0;
   localparam int K_CPIN  = 1;
   localparam int K_CPOUT = 2;
   localparam int K_LOAD  = 3;
   localparam int K_STORE = 4;
   localparam int K_BR    = 5;
   localparam int K_JMP   = 6;
   localparam int K_LDST  = 7;
   localparam int K_HALT  = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dec_mem_read = 1'b0;
   logic        dec_mem_write = 1'b0;
   logic        dec_branch = 1'b0;
   logic        dec_jump = 1'b0;
   logic        dec_halt = 1'b0;
   logic        dec_cpin = 1'b0;
   logic        dec_cpout = 1'b0;
   logic [1:0]  dec_write_src = 2'b00;
   logic        branch_cond = 1'b0;
   logic [7:0]  target = 8'h00;
   logic        dmem_ready = 1'b0;

   logic        fetch_req, ir_load, dmem_req, dmem_we, reg_we, res_we, halted;
   logic [7:0]  pc;
   logic [15:0] cycle_count, retired_count;

   logic        s_unused_fetch_req, s_unused_ir_load, s_unused_dmem_req, s_unused_dmem_we;
   logic        s_unused_reg_we, s_unused_res_we, s_unused_halted;
   logic [7:0]  s_unused_pc;
   logic [1:0]  s_cycle_count, s_retired_count;

   int total = 0;
   int bad = 0;

   // Reference model state
   int exp_pc = 0;
   int exp_ret = 0;
   int exp_cyc = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .fetch_req(fetch_req),
      .imem_ready(imem_ready), .ir_load(ir_load), .dec_mem_read(dec_mem_read),
      .dec_mem_write(dec_mem_write), .dec_branch(dec_branch), .dec_jump(dec_jump),
      .dec_halt(dec_halt), .dec_cpin(dec_cpin), .dec_cpout(dec_cpout),
      .dec_write_src(dec_write_src), .branch_cond(branch_cond), .target(target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .reg_we(reg_we),
      .res_we(res_we), .pc(pc), .halted(halted), .cycle_count(cycle_count),
      .retired_count(retired_count)
   );

   cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(2)) dut_s (
      .clk(clk), .reset_n(reset_n), .start(start), .fetch_req(s_unused_fetch_req),
      .imem_ready(imem_ready), .ir_load(s_unused_ir_load), .dec_mem_read(dec_mem_read),
      .dec_mem_write(dec_mem_write), .dec_branch(dec_branch), .dec_jump(dec_jump),
      .dec_halt(dec_halt), .dec_cpin(dec_cpin), .dec_cpout(dec_cpout),
      .dec_write_src(dec_write_src), .branch_cond(branch_cond), .target(target),
      .dmem_req(s_unused_dmem_req), .dmem_we(s_unused_dmem_we), .dmem_ready(dmem_ready),
      .reg_we(s_unused_reg_we), .res_we(s_unused_res_we), .pc(s_unused_pc),
      .halted(s_unused_halted), .cycle_count(s_cycle_count),
      .retired_count(s_retired_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting at posedge+1 of its first FETCH cycle; returns at
   // posedge+1 of the next instruction's first cycle (or of the first HALT cycle).
   task automatic run_instr(input string name, input int kind, input int iw, input int dw,
                            input bit cond, input logic [7:0] tgt, input bit also_br);
      int  cyc = 0, n_ld = 0, n_reg = 0, n_res = 0, n_dreq = 0, n_dwe = 0;
      int  iwr = iw, dwr = dw;
      int  lat, e_reg, e_res, e_dreq, e_dwe, e_pc;
      bit  loaded = 0, done = 0, is_mem;

      dec_mem_read = 0; dec_mem_write = 0; dec_branch = 0; dec_jump = 0; dec_halt = 0;
      dec_cpin = 0; dec_cpout = 0; dec_write_src = 2'($urandom_range(0, 3));
      branch_cond = cond; target = tgt;
      case (kind)
         K_CPIN:  dec_cpin = 1;
         K_CPOUT: begin dec_cpout = 1; dec_write_src = 2'b10; end
         K_LOAD:  begin dec_mem_read = 1; dec_write_src = 2'b00; end
         K_STORE: dec_mem_write = 1;
         K_LDST:  begin dec_mem_read = 1; dec_mem_write = 1; end
         K_BR:    dec_branch = 1;
         K_JMP:   begin dec_jump = 1; dec_branch = also_br; end
         K_HALT:  dec_halt = 1;
         default: ;
      endcase

      // Model: fixed latencies for zero-wait memories, each wait cycle adds one.
      is_mem = (kind == K_LOAD) || (kind == K_STORE) || (kind == K_LDST);
      case (kind)
         K_LOAD, K_LDST: lat = 5;
         K_BR, K_JMP:    lat = 3;
         K_HALT:         lat = 2;
         default:        lat = 4;
      endcase
      lat = lat + iw + (is_mem ? dw : 0);
      e_reg  = (kind == K_ALU || kind == K_CPOUT || kind == K_LOAD || kind == K_LDST) ? 1 : 0;
      e_res  = (kind == K_CPIN) ? 1 : 0;
      e_dreq = is_mem ? dw + 1 : 0;
      e_dwe  = (kind == K_STORE) ? dw + 1 : 0;
      if (kind == K_JMP)       e_pc = int'(tgt);
      else if (kind == K_BR)   e_pc = cond ? int'(tgt) : (exp_pc + 1) % 256;
      else if (kind == K_HALT) e_pc = exp_pc;
      else                     e_pc = (exp_pc + 1) % 256;

      while (!done && cyc < 64) begin
         imem_ready = fetch_req && !loaded && (iwr == 0);
         if (fetch_req && !loaded && iwr > 0) iwr--;
         dmem_ready = dmem_req && (dwr == 0);
         if (dmem_req && dwr > 0) dwr--;
         @(negedge clk);
         if (ir_load) begin loaded = 1; n_ld++; end
         if (reg_we) n_reg++;
         if (res_we) n_res++;
         if (dmem_req) n_dreq++;
         if (dmem_req && dmem_we) n_dwe++;
         cyc++;
         next_cycle();
         if (loaded && (fetch_req || halted)) done = 1;
      end
      imem_ready = 0;
      dmem_ready = 0;

      exp_pc  = e_pc;
      exp_ret = exp_ret + 1;
      exp_cyc = exp_cyc + lat;

      check({name, ".timeout"}, 32'(done), 32'd1);
      check({name, ".cycles"}, 32'(cyc), 32'(lat));
      check({name, ".ir_load"}, 32'(n_ld), 32'd1);
      check({name, ".reg_we"}, 32'(n_reg), 32'(e_reg));
      check({name, ".res_we"}, 32'(n_res), 32'(e_res));
      check({name, ".dmem_req"}, 32'(n_dreq), 32'(e_dreq));
      check({name, ".dmem_we"}, 32'(n_dwe), 32'(e_dwe));
      check({name, ".pc"}, 32'(pc), 32'(exp_pc));
      check({name, ".halted"}, 32'(halted), 32'(kind == K_HALT));
      check({name, ".retired"}, 32'(retired_count), 32'(exp_ret));
      check({name, ".cycles_cnt"}, 32'(cycle_count), 32'(exp_cyc));
      check({name, ".sat_retired"}, 32'(s_retired_count), 32'(sat3(exp_ret)));
      check({name, ".sat_cycles"}, 32'(s_cycle_count), 32'(sat3(exp_cyc)));
   endtask

   task automatic check_reset_state(input string name);
      check({name, ".pc"}, 32'(pc), 32'h0);
      check({name, ".cycle_count"}, 32'(cycle_count), 32'h0);
      check({name, ".retired_count"}, 32'(retired_count), 32'h0);
      check({name, ".fetch_req"}, 32'(fetch_req), 32'h0);
      check({name, ".dmem_req"}, 32'(dmem_req), 32'h0);
      check({name, ".dmem_we"}, 32'(dmem_we), 32'h0);
      check({name, ".we"}, 32'({reg_we, res_we}), 32'h0);
      check({name, ".halted"}, 32'(halted), 32'h0);
      exp_pc = 0; exp_ret = 0; exp_cyc = 0;
   endtask

   task automatic do_start();
      start = 1;
      next_cycle();
      start = 0;
   endtask

   initial begin
      int kind;
      int cyc_frozen;

      // Reset and idle state
      reset_n = 0;
      repeat (2) next_cycle();
      reset_n = 1;
      check_reset_state("reset");
      next_cycle();
      check("idle_no_fetch", 32'(fetch_req), 32'h0);

      do_start();
      check("start_fetch", 32'(fetch_req), 32'h1);

      // Directed cases
      run_instr("alu", K_ALU, 0, 0, 0, 8'h00, 0);
      run_instr("load_wait3", K_LOAD, 0, 3, 0, 8'h00, 0);
      run_instr("br_taken", K_BR, 0, 0, 1, 8'h40, 0);
      run_instr("br_not", K_BR, 0, 0, 0, 8'h40, 0);
      run_instr("jmp_over_br", K_JMP, 0, 0, 0, 8'hFF, 1);
      run_instr("alu_wrap", K_ALU, 0, 0, 0, 8'h00, 0);
      run_instr("store", K_STORE, 1, 0, 0, 8'h00, 0);
      run_instr("ldst", K_LDST, 0, 1, 0, 8'h00, 0);
      run_instr("cpin", K_CPIN, 2, 0, 0, 8'h00, 0);

      // Random instruction mix with random memory wait states
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 7);
         run_instr($sformatf("rnd%0d", i), kind, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a stalled store: the write must be abandoned
      dec_mem_read = 0; dec_mem_write = 1; dec_branch = 0; dec_jump = 0; dec_halt = 0;
      dec_cpin = 0; dec_cpout = 0;
      imem_ready = 1;
      next_cycle();
      imem_ready = 0;
      repeat (2) next_cycle();
      check("mid_store.dmem_req", 32'(dmem_req), 32'h1);
      check("mid_store.dmem_we", 32'(dmem_we), 32'h1);
      next_cycle();
      reset_n = 0;
      next_cycle();
      reset_n = 1;
      check_reset_state("mid_store_reset");
      next_cycle();
      check("post_reset_idle.dmem_req", 32'(dmem_req), 32'h0);
      check("post_reset_idle.fetch_req", 32'(fetch_req), 32'h0);

      // Halt after two instructions; start must then be ignored
      do_start();
      run_instr("h_alu0", K_ALU, 0, 0, 0, 8'h00, 0);
      run_instr("h_alu1", K_CPOUT, 1, 0, 0, 8'h00, 0);
      run_instr("halt", K_HALT, 1, 0, 0, 8'h00, 0);
      check("halt.retired3", 32'(retired_count), 32'd3);
      cyc_frozen = exp_cyc;
      dec_halt = 0;
      start = 1;
      repeat (3) next_cycle();
      start = 0;
      next_cycle();
      check("halt.sticky", 32'(halted), 32'h1);
      check("halt.no_fetch", 32'(fetch_req), 32'h0);
      check("halt.cycles_frozen", 32'(cycle_count), 32'(cyc_frozen));
      check("halt.retired_frozen", 32'(retired_count), 32'd3);
      check("halt.pc_held", 32'(pc), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
